// File: rtl/sha256_ctrl_pkg.sv
// Shared definitions for the SHA-256 sequencer: datapath state codes,
// bus widths, the controller's internal phases and the length arithmetic.
package sha256_ctrl_pkg;

  localparam int ADDR_W = 7;
  localparam int LEN_W  = 15;

  localparam logic [2:0] ST_INIT  = 3'b000;
  localparam logic [2:0] ST_WRITE = 3'b001;
  localparam logic [2:0] ST_PAD   = 3'b010;
  localparam logic [2:0] ST_FETCH = 3'b011;
  localparam logic [2:0] ST_SCHED = 3'b100;
  localparam logic [2:0] ST_COMP  = 3'b101;
  localparam logic [2:0] ST_UPD   = 3'b110;
  localparam logic [2:0] ST_HASH  = 3'b111;

  // Each phase names the datapath code the controller will present after the next edge
  typedef enum logic [3:0] {
    SEQ_IDLE,
    SEQ_LOAD,
    SEQ_PAD,
    SEQ_FETCH,
    SEQ_SCHED,
    SEQ_COMP,
    SEQ_UPD,
    SEQ_OUT,
    SEQ_FIN
  } seq_e;

  // Number of 32-bit words needed to hold len bits
  function automatic logic [15:0] wordsFor(input logic [LEN_W-1:0] len);
    return (16'(len) + 16'd31) >> 5;
  endfunction

  // Number of 512-bit chunks after padding (the 1 bit plus 64-bit length field)
  function automatic logic [ADDR_W-1:0] chunksFor(input logic [LEN_W-1:0] len);
    return 7'((16'(len) + 16'd64) >> 9) + 7'd1;
  endfunction

endpackage

// File: rtl/sha256_hold_timer.sv
// Loadable down-counter that keeps a datapath phase active for a set number
// of cycles. expired_o is high once the count has reached zero; the count
// then stays at zero until it is loaded again.
module sha256_hold_timer #(
  parameter int W = 7
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] loadVal_i,
  input  logic         dec_i,
  output logic         expired_o
);

  logic [W-1:0] count_q, count_d;

  // Load takes priority over counting down; counting stops at zero
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = loadVal_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/sha256_sequencer.sv
// Top-level controller for the SHA-256 datapath. Takes a message length and
// a word stream, then walks the Preprocessing and Chunks blocks through
// load, pad and the per-chunk fetch/schedule/compress/update loop, ending
// with the hash phase and a done pulse. Every output is a register.
module sha256_sequencer
  import sha256_ctrl_pkg::*;
#(
  parameter int DEPTH        = 100,
  parameter int MAX_WORDS    = 98,
  parameter int SCHED_CYCLES = 1,
  parameter int COMP_CYCLES  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len_in,
  output logic              ready,
  input  logic [31:0]       word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic [2:0]        state,
  output logic [ADDR_W-1:0] indirizzo,
  output logic [31:0]       message,
  output logic [LEN_W-1:0]  mess_lenght,
  output logic              busy,
  output logic              done,
  output logic              len_err
);

  // The last word index must stay below the Preprocessing memory depth
  localparam logic [15:0] WORD_LIMIT =
    (MAX_WORDS < DEPTH - 1) ? 16'(MAX_WORDS) : 16'(DEPTH - 2);
  localparam logic [ADDR_W-1:0] SCHED_LOAD = 7'(SCHED_CYCLES - 1);
  localparam logic [ADDR_W-1:0] COMP_LOAD  = 7'(COMP_CYCLES - 1);

  seq_e              fsm_q, fsm_d;
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] indir_q, indir_d;
  logic [31:0]       msg_q, msg_d;
  logic [LEN_W-1:0]  mlen_q, mlen_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              lenErr_q, lenErr_d;
  logic              ready_q, ready_d;
  logic              wordReady_q, wordReady_d;
  logic [ADDR_W-1:0] wordCnt_q, wordCnt_d;
  logic [ADDR_W-1:0] nWords_q, nWords_d;
  logic [ADDR_W-1:0] chunkCnt_q, chunkCnt_d;
  logic [ADDR_W-1:0] nChunks_q, nChunks_d;

  logic              tmrLoad;
  logic [ADDR_W-1:0] tmrLoadVal;
  logic              tmrDec;
  logic              tmrExpired;
  logic [15:0]       wordsCalc;

  assign wordsCalc = wordsFor(len_in);

  sha256_hold_timer #(.W(ADDR_W)) u_holdTimer (
    .clock     (clock),
    .reset     (reset),
    .load_i    (tmrLoad),
    .loadVal_i (tmrLoadVal),
    .dec_i     (tmrDec),
    .expired_o (tmrExpired)
  );

  // Next-phase and next-output logic; registers hold unless a phase changes them
  always_comb begin
    fsm_d       = fsm_q;
    state_d     = ST_INIT;
    indir_d     = indir_q;
    msg_d       = msg_q;
    mlen_d      = mlen_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    lenErr_d    = 1'b0;
    ready_d     = ready_q;
    wordReady_d = wordReady_q;
    wordCnt_d   = wordCnt_q;
    nWords_d    = nWords_q;
    chunkCnt_d  = chunkCnt_q;
    nChunks_d   = nChunks_q;
    tmrLoad     = 1'b0;
    tmrLoadVal  = SCHED_LOAD;
    tmrDec      = 1'b0;

    case (fsm_q)
      SEQ_IDLE: begin
        ready_d = 1'b1;
        if (start && ready_q) begin
          if (wordsCalc > WORD_LIMIT) begin
            lenErr_d = 1'b1;
          end else begin
            mlen_d     = len_in;
            busy_d     = 1'b1;
            ready_d    = 1'b0;
            nWords_d   = wordsCalc[ADDR_W-1:0];
            nChunks_d  = chunksFor(len_in);
            wordCnt_d  = '0;
            chunkCnt_d = '0;
            if (wordsCalc == 16'd0) begin
              fsm_d = SEQ_PAD;
            end else begin
              fsm_d       = SEQ_LOAD;
              wordReady_d = 1'b1;
            end
          end
        end
      end
      SEQ_LOAD: begin
        if (word_valid) begin
          state_d   = ST_WRITE;
          msg_d     = word_in;
          indir_d   = wordCnt_q;
          wordCnt_d = wordCnt_q + 7'd1;
          if (wordCnt_q + 7'd1 == nWords_q) begin
            fsm_d       = SEQ_PAD;
            wordReady_d = 1'b0;
          end
        end
      end
      SEQ_PAD: begin
        state_d = ST_PAD;
        indir_d = (nWords_q == '0) ? '0 : nWords_q - 7'd1;
        fsm_d   = SEQ_FETCH;
      end
      SEQ_FETCH: begin
        state_d    = ST_FETCH;
        tmrLoad    = 1'b1;
        tmrLoadVal = SCHED_LOAD;
        fsm_d      = SEQ_SCHED;
      end
      SEQ_SCHED: begin
        state_d = ST_SCHED;
        if (tmrExpired) begin
          tmrLoad    = 1'b1;
          tmrLoadVal = COMP_LOAD;
          fsm_d      = SEQ_COMP;
        end else begin
          tmrDec = 1'b1;
        end
      end
      SEQ_COMP: begin
        state_d = ST_COMP;
        if (tmrExpired) begin
          fsm_d = SEQ_UPD;
        end else begin
          tmrDec = 1'b1;
        end
      end
      SEQ_UPD: begin
        state_d    = ST_UPD;
        chunkCnt_d = chunkCnt_q + 7'd1;
        if (chunkCnt_q + 7'd1 == nChunks_q) begin
          fsm_d = SEQ_OUT;
        end else begin
          fsm_d = SEQ_FETCH;
        end
      end
      SEQ_OUT: begin
        state_d = ST_HASH;
        fsm_d   = SEQ_FIN;
      end
      SEQ_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        fsm_d   = SEQ_IDLE;
      end
      default: begin
        fsm_d = SEQ_IDLE;
      end
    endcase
  end

  // Phase and output registers; reset abandons any transfer in progress
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q       <= SEQ_IDLE;
      state_q     <= ST_INIT;
      indir_q     <= '0;
      msg_q       <= '0;
      mlen_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      lenErr_q    <= 1'b0;
      ready_q     <= 1'b1;
      wordReady_q <= 1'b0;
      wordCnt_q   <= '0;
      nWords_q    <= '0;
      chunkCnt_q  <= '0;
      nChunks_q   <= '0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      indir_q     <= indir_d;
      msg_q       <= msg_d;
      mlen_q      <= mlen_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      lenErr_q    <= lenErr_d;
      ready_q     <= ready_d;
      wordReady_q <= wordReady_d;
      wordCnt_q   <= wordCnt_d;
      nWords_q    <= nWords_d;
      chunkCnt_q  <= chunkCnt_d;
      nChunks_q   <= nChunks_d;
    end
  end

  assign state       = state_q;
  assign indirizzo   = indir_q;
  assign message     = msg_q;
  assign mess_lenght = mlen_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign len_err     = lenErr_q;
  assign ready       = ready_q;
  assign word_ready  = wordReady_q;

endmodule

// File: tb/tb_sha256_sequencer.sv
// Scoreboard bench for sha256_sequencer with SCHED_CYCLES=2, COMP_CYCLES=5.
// Stimulus pushes expected datapath events and cycle snapshots; the monitor
// pops and compares them on the falling edge.
`timescale 1ns/1ps
module tb_sha256_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [14:0] len_in;
  logic        ready;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic [2:0]  state;
  logic [6:0]  indirizzo;
  logic [31:0] message;
  logic [14:0] mess_lenght;
  logic        busy;
  logic        done;
  logic        len_err;

  typedef struct {
    int          cyc;
    logic [2:0]  st;
    logic [6:0]  addr;
    logic [31:0] msg;
    logic [14:0] mlen;
    logic        busy;
    logic        rdy;
    logic        wr;
    logic        done;
    logic        lerr;
    bit          chkAddr;
    bit          chkMsg;
    bit          chkLen;
  } ev_t;

  typedef struct {
    int          cyc;
    int          kind;
    logic [2:0]  st;
    logic        busy;
    logic        rdy;
    logic        wr;
    logic        done;
    logic        lerr;
  } probe_t;

  ev_t         evq[$];
  probe_t      prq[$];
  int          cyc = 0;
  int          nCompared = 0;
  int          nMismatched = 0;
  int          lastDoneCyc = -1;
  bit          monEn = 1'b0;
  logic [31:0] wordsArr [0:127];
  ev_t         mEv;
  probe_t      mPr;
  bit          mOk;

  sha256_sequencer #(
    .DEPTH        (100),
    .MAX_WORDS    (98),
    .SCHED_CYCLES (2),
    .COMP_CYCLES  (5)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .len_in      (len_in),
    .ready       (ready),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .state       (state),
    .indirizzo   (indirizzo),
    .message     (message),
    .mess_lenght (mess_lenght),
    .busy        (busy),
    .done        (done),
    .len_err     (len_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic string probeName(input int kind);
    case (kind)
      0: return "reset_state";
      1: return "idle_snapshot";
      2: return "drain";
      default: return "comp_reached";
    endcase
  endfunction

  // Monitor: snapshot probes at their cycle, datapath events whenever presented
  always @(negedge clock) begin
    while (prq.size() != 0 && prq[0].cyc <= cyc) begin
      mPr = prq.pop_front();
      nCompared++;
      mOk = (mPr.cyc == cyc);
      case (mPr.kind)
        0: mOk = mOk && state == mPr.st && busy == mPr.busy && ready == mPr.rdy &&
                 word_ready == mPr.wr && done == mPr.done && len_err == mPr.lerr &&
                 indirizzo == 7'd0 && message == 32'd0 && mess_lenght == 15'd0;
        1: mOk = mOk && state == mPr.st && busy == mPr.busy && ready == mPr.rdy &&
                 word_ready == mPr.wr && done == mPr.done && len_err == mPr.lerr;
        2: mOk = mOk && (evq.size() == 0);
        default: mOk = mOk && state == mPr.st;
      endcase
      if (!mOk) begin
        nMismatched++;
        $display("[TB] FAIL %s cyc=%0d got st=%b busy=%b rdy=%b wr=%b done=%b lerr=%b addr=%0d msg=%h mlen=%0d pending=%0d want st=%b busy=%b rdy=%b wr=%b done=%b lerr=%b pending=0",
                 probeName(mPr.kind), mPr.cyc, state, busy, ready, word_ready, done, len_err,
                 indirizzo, message, mess_lenght, evq.size(),
                 mPr.st, mPr.busy, mPr.rdy, mPr.wr, mPr.done, mPr.lerr);
      end
    end
    if (monEn && (state != 3'b000 || done || len_err)) begin
      if (done) lastDoneCyc = cyc;
      nCompared++;
      if (evq.size() == 0) begin
        nMismatched++;
        $display("[TB] FAIL unexpected_event cyc=%0d got st=%b done=%b lerr=%b want no event",
                 cyc, state, done, len_err);
      end else begin
        mEv = evq.pop_front();
        mOk = (mEv.cyc == cyc) && state == mEv.st && busy == mEv.busy && ready == mEv.rdy &&
              word_ready == mEv.wr && done == mEv.done && len_err == mEv.lerr &&
              (!mEv.chkAddr || indirizzo == mEv.addr) &&
              (!mEv.chkMsg || message == mEv.msg) &&
              (!mEv.chkLen || mess_lenght == mEv.mlen);
        if (!mOk) begin
          nMismatched++;
          $display("[TB] FAIL event got cyc=%0d st=%b addr=%0d msg=%h busy=%b rdy=%b wr=%b done=%b lerr=%b mlen=%0d want cyc=%0d st=%b addr=%0d msg=%h busy=%b rdy=%b wr=%b done=%b lerr=%b mlen=%0d",
                   cyc, state, indirizzo, message, busy, ready, word_ready, done, len_err, mess_lenght,
                   mEv.cyc, mEv.st, mEv.addr, mEv.msg, mEv.busy, mEv.rdy, mEv.wr, mEv.done, mEv.lerr, mEv.mlen);
        end
      end
    end
  end

  task automatic pushEv(input int c, input logic [2:0] st, input logic [6:0] addr,
                        input logic [31:0] msg, input int len, input logic bsy,
                        input logic rdy, input logic wr, input logic dn, input logic le,
                        input bit chkAddr, input bit chkMsg, input bit chkLen);
    ev_t e;
    e.cyc = c; e.st = st; e.addr = addr; e.msg = msg; e.mlen = 15'(len);
    e.busy = bsy; e.rdy = rdy; e.wr = wr; e.done = dn; e.lerr = le;
    e.chkAddr = chkAddr; e.chkMsg = chkMsg; e.chkLen = chkLen;
    evq.push_back(e);
  endtask

  task automatic pushProbe(input int c, input int kind, input logic [2:0] st,
                           input logic bsy, input logic rdy, input logic wr,
                           input logic dn, input logic le);
    probe_t p;
    p.cyc = c; p.kind = kind; p.st = st; p.busy = bsy; p.rdy = rdy;
    p.wr = wr; p.done = dn; p.lerr = le;
    prq.push_back(p);
  endtask

  // One accepted hash run; handDone is the hand-computed done cycle after start
  task automatic applyStimulus(input int len, input int gap, input bit poke,
                               input bit holdValid, input int handDone);
    int nw, nch, k, startCyc;
    nw  = (len + 31) / 32;
    nch = (len + 64) / 512 + 1;
    @(posedge clock); #1;
    startCyc = cyc;
    start = 1'b1; len_in = 15'(len);
    @(posedge clock); #1;
    start = 1'b0;
    k = 0;
    pushProbe(startCyc + 1, 1, 3'b000, 1'b1, 1'b0, (nw != 0), 1'b0, 1'b0);
    for (int i = 0; i < nw; i++) begin
      if (i == 1) begin
        for (int g = 0; g < gap; g++) begin
          word_valid = 1'b0;
          @(posedge clock); #1;
          k++;
          pushProbe(startCyc + 1 + k, 1, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        end
      end
      word_valid = 1'b1; word_in = wordsArr[i];
      if (poke && i == 2) begin
        start = 1'b1; len_in = 15'd24;
      end
      @(posedge clock); #1;
      k++;
      start = 1'b0; len_in = 15'(len);
      pushEv(startCyc + 1 + k, 3'b001, 7'(i), wordsArr[i], len, 1'b1, 1'b0,
             (i != nw - 1), 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    end
    word_valid = holdValid; word_in = 32'hdeadbeef;
    k++;
    pushEv(startCyc + 1 + k, 3'b010, (nw == 0) ? 7'd0 : 7'(nw - 1), 32'd0, len,
           1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < nch; c++) begin
      k++;
      pushEv(startCyc + 1 + k, 3'b011, 7'd0, 32'd0, len, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int s = 0; s < 2; s++) begin
        k++;
        pushEv(startCyc + 1 + k, 3'b100, 7'd0, 32'd0, len, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      for (int s = 0; s < 5; s++) begin
        k++;
        pushEv(startCyc + 1 + k, 3'b101, 7'd0, 32'd0, len, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      k++;
      pushEv(startCyc + 1 + k, 3'b110, 7'd0, 32'd0, len, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    k++;
    pushEv(startCyc + 1 + k, 3'b111, 7'd0, 32'd0, len, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pushEv(startCyc + handDone, 3'b000, 7'd0, 32'd0, len, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    if (holdValid) begin
      repeat (2) @(posedge clock);
      #1 word_valid = 1'b0;
    end
    for (int t = 0; t < 400 && lastDoneCyc <= startCyc; t++) @(posedge clock);
    repeat (3) @(posedge clock);
    #1 pushProbe(cyc, 2, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Over-length start: one len_err pulse, controller stays idle
  task automatic applyReject(input int len);
    int startCyc;
    @(posedge clock); #1;
    startCyc = cyc;
    start = 1'b1; len_in = 15'(len);
    @(posedge clock); #1;
    start = 1'b0;
    pushEv(startCyc + 1, 3'b000, 7'd0, 32'd0, len, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clock); #1;
    pushProbe(cyc, 1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1 pushProbe(cyc, 2, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; len_in = '0; word_in = '0; word_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1 pushProbe(cyc, 0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clock); #1;
    pushProbe(cyc, 0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    monEn = 1'b1;

    // "abc": one word, word_valid left high past the last word
    wordsArr[0] = 32'h61626380;
    applyStimulus(24, 0, 1'b0, 1'b1, 14);

    // 448-bit message: two chunks, with a start pulse while busy
    wordsArr[0]  = 32'h61626364; wordsArr[1]  = 32'h62636465;
    wordsArr[2]  = 32'h63646566; wordsArr[3]  = 32'h64656667;
    wordsArr[4]  = 32'h65666768; wordsArr[5]  = 32'h66676869;
    wordsArr[6]  = 32'h6768696a; wordsArr[7]  = 32'h68696a6b;
    wordsArr[8]  = 32'h696a6b6c; wordsArr[9]  = 32'h6a6b6c6d;
    wordsArr[10] = 32'h6b6c6d6e; wordsArr[11] = 32'h6c6d6e6f;
    wordsArr[12] = 32'h6d6e6f70; wordsArr[13] = 32'h6e6f7071;
    applyStimulus(448, 0, 1'b1, 1'b0, 36);

    // Empty message: straight to PAD
    applyStimulus(0, 0, 1'b0, 1'b0, 13);

    // Two words with a three-cycle valid gap
    wordsArr[0] = 32'h01234567; wordsArr[1] = 32'h89abcdef;
    applyStimulus(64, 3, 1'b0, 1'b0, 18);

    // One word too many
    applyReject(3137);

    // Largest accepted length: 98 words, 7 chunks
    for (int i = 0; i < 98; i++) wordsArr[i] = 32'(i) * 32'h01010101 + 32'h00c0ffee;
    applyStimulus(3136, 0, 1'b0, 1'b0, 165);

    // Reset in the middle of COMP, then a clean run
    monEn = 1'b0;
    @(posedge clock); #1;
    start = 1'b1; len_in = 15'd24;
    @(posedge clock); #1;
    start = 1'b0; word_valid = 1'b1; word_in = 32'h61626380;
    @(posedge clock); #1;
    word_valid = 1'b0;
    for (int t = 0; t < 60 && state != 3'b101; t++) begin
      @(posedge clock); #1;
    end
    pushProbe(cyc, 3, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    pushProbe(cyc, 1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clock); #1;
    pushProbe(cyc, 1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clock); #1;
    monEn = 1'b1;
    wordsArr[0] = 32'h61626380;
    applyStimulus(24, 0, 1'b0, 1'b0, 14);

    repeat (4) @(posedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/sha256_sequencer.md
Name: sha256_sequencer

Overview:
Top-level controller for the SHA-256 datapath (Preprocessing + Chunks). It accepts a message length and a stream of 32-bit words through a valid/ready handshake, then drives the shared 3-bit `state` code, `indirizzo`, `message` and `mess_lenght` buses. It walks both datapath modules through load, pad, and per-chunk fetch/schedule/compress/update, and ends with final hash output. It owns chunk counting and signals completion, so the datapath never needs an external testbench-driven state sequence.

Parameters:
- DEPTH, 100: word-memory depth of Preprocessing.
- MAX_WORDS, 98: largest accepted ceil(len/32). Keeps index+1 below DEPTH.
- SCHED_CYCLES, 1: cycles `state`=100 is held (range 1..15).
- COMP_CYCLES, 1: cycles `state`=101 is held (range 1..127).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  begin hash; honoured only when ready=1
- len_in  in  15  message length in bits
- ready  out  1  idle, start accepted
- word_in  in  32  message word, first word first
- word_valid  in  1  word_in valid
- word_ready  out  1  controller accepts a word this cycle
- state  out  3  datapath state code
- indirizzo  out  7  Preprocessing word address
- message  out  32  word to Preprocessing
- mess_lenght  out  15  latched length to Preprocessing
- busy  out  1  high from start accept until done
- done  out  1  one-cycle pulse; hash available on Chunks HASH
- len_err  out  1  one-cycle pulse; start rejected

Behaviour:
- Interface: one clock, `clock`; reset `reset` is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - state=000, indirizzo=0, message=0, mess_lenght=0
  - busy=0, done=0, len_err=0, word_ready=0, ready=1
  - internal counters 0, FSM in IDLE
- Reset mid-operation: abandons the transfer on the next edge and returns to IDLE with reset values. The datapath re-initialises because state=000.
- On start acceptance, latch:
  - n_words = ceil(len/32)
  - n_chunks = floor((len+64)/512)+1
- FSM (state output code in brackets):
  - IDLE [000]: ready=1.
    - start with n_words>MAX_WORDS: pulse len_err next cycle, stay IDLE.
    - start otherwise: latch mess_lenght=len_in, busy=1. Go to LOAD, or to PAD if n_words=0.
  - LOAD: word_ready=1.
    - Each cycle word_valid=1: state=001, message=word_in, indirizzo=word_cnt, then word_cnt++.
    - Cycles with word_valid=0: state=000 (no datapath write).
    - After the n_words-th word is accepted: go to PAD.
    - word_ready drops in the cycle following the last accept.
  - PAD [010], 1 cycle: indirizzo = n_words-1 (0 if n_words=0). Go to FETCH.
  - FETCH [011], 1 cycle: chunk register updates on this edge. Go to SCHED.
  - SCHED [100], held SCHED_CYCLES cycles. Go to COMP.
  - COMP [101], held COMP_CYCLES cycles. Go to UPD.
  - UPD [110], 1 cycle, chunk_cnt++.
    - If chunk_cnt+1 == n_chunks: go to OUT.
    - Otherwise: go to FETCH.
  - OUT [111], 1 cycle. Next cycle: done=1, busy=0, state=000, return to IDLE.
- start while busy is ignored, with no effect on counters.
- word_valid outside LOAD is ignored.
- Latency with default params: 1 (accept) + n_words (no stalls) + 1 (PAD) + 4·n_chunks + 1 (OUT), then done.
- Width rules:
  - word_cnt is 7 bits; it never wraps because MAX_WORDS<128.
  - chunk_cnt is 7 bits; max n_chunks is 7 given MAX_WORDS.
  - Hold counters saturate at 0.

Decomposition:
- Package sha256_ctrl_pkg:
  - state codes ST_INIT=000, ST_WRITE=001, ST_PAD=010, ST_FETCH=011, ST_SCHED=100, ST_COMP=101, ST_UPD=110, ST_HASH=111
  - ADDR_W=7, LEN_W=15
- Sub-module sha256_hold_timer: loadable down-counter with `expired` flag, used for the SCHED and COMP holds.
- Chunk arithmetic stays inline.

Test Plan:
- len_in=24, word 0x61626380, word_valid steady → state sequence 001,010,011,100,101,110,111. done in cycle 9 after start; HASH=ba7816bf…f20015ad.
- len_in=448, 14 words → n_chunks=2; FETCH…UPD cycle runs twice; done at 1+14+1+8+1 cycles.
- len_in=0, start → no 001 cycle; PAD with indirizzo=0; one chunk; HASH=e3b0c442…7852b855.
- len_in=64, word_valid low for 3 cycles between the two words → state=000 during the gap, indirizzo 0 then 1; result matches the no-gap run.
- len_in=3137 → len_err pulses once, ready stays 1, busy stays 0, state stays 000.
- reset asserted during COMP with SCHED_CYCLES=2, COMP_CYCLES=5 → next cycle state=000, busy=0, ready=1; a following len_in=24 run still produces the correct hash.
